// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S sine transmitter.
//   SLOT_BITS    : bit clocks per channel slot
//   FRAME_BITS   : bit clocks per stereo frame (left + right)
//   SAMPLE_W_DEF : default sample width
//   state_e      : controller states
package i2s_pkg;

  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;
  localparam int SAMPLE_W_DEF = 24;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_sine_tx_if.sv
// Bundle of the sample-stream and I2S-output signals of i2s_sine_tx.
//   run, data_valid, data_in              : from the sample source
//   bclk, lrclk, sdata, sample_req,
//   underrun                              : from the transmitter
// master : sample source / test driver side
// slave  : transmitter side
interface i2s_sine_tx_if #(
  parameter int SAMPLE_W = 24
);

  logic                run;
  logic                data_valid;
  logic [SAMPLE_W-1:0] data_in;
  logic                bclk;
  logic                lrclk;
  logic                sdata;
  logic                sample_req;
  logic                underrun;

  modport master (
    output run, data_valid, data_in,
    input  bclk, lrclk, sdata, sample_req, underrun
  );

  modport slave (
    input  run, data_valid, data_in,
    output bclk, lrclk, sdata, sample_req, underrun
  );

endinterface

// File: rtl/i2s_bclk_div.sv
// Bit-clock divider: toggles bclk every BCLK_DIV enabled clk cycles.
//   i_clk     : system clock
//   i_reset   : synchronous active-high reset
//   i_en      : count enable; low clears the counter and forces bclk low
//   o_bclk    : registered bit clock
//   o_rise_en : high in the cycle whose edge takes bclk 0->1
//   o_fall_en : high in the cycle whose edge takes bclk 1->0
module i2s_bclk_div #(
  parameter int BCLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_bclk,
  output logic o_rise_en,
  output logic o_fall_en
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(BCLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic          r_bclk;
  logic          w_tc;

  assign w_tc = i_en && (r_div_cnt == TC);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_bclk    = r_bclk;
  assign o_rise_en = w_tc && !r_bclk;
  assign o_fall_en = w_tc && r_bclk;

endmodule

// File: rtl/i2s_sine_tx.sv
// Philips-I2S transmitter for a mono sample stream. Each sample is sent
// MSB first, one bclk after the lrclk change, identically in the left and
// right slots. A frame is latched on RUN entry and at every 64-bit wrap;
// a latch with no fresh sample repeats the last one and sets a sticky
// underrun flag.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   bus.run        : enable; low returns to IDLE (mid-frame abort allowed)
//   bus.data_valid : one-cycle strobe qualifying bus.data_in
//   bus.data_in    : two's-complement sample
//   bus.bclk       : bit clock, period 2*BCLK_DIV clk
//   bus.lrclk      : word select, 0 = left, 1 = right
//   bus.sdata      : serial data, changes only on bclk falling edges
//   bus.sample_req : one-cycle pulse per frame latch
//   bus.underrun   : sticky stale-frame flag, cleared only by reset
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | outputs low (underrun held); holding register still accepts data
// RUN   | bclk running, frame serialized, latch at each 63->0 wrap
module i2s_sine_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 8,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input logic          i_clk,
  input logic          i_reset,
  i2s_sine_tx_if.slave bus
);

  localparam int BIT_CNT_W = $clog2(FRAME_BITS);
  localparam int POS_W     = $clog2(SLOT_BITS);

  localparam logic [0:0]           S_IDLE   = IDLE;
  localparam logic [0:0]           S_RUN    = RUN;
  localparam logic [POS_W-1:0]     LAST_POS = POS_W'(SAMPLE_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  // Slot position 0 is the I2S one-bit delay; positions past the sample
  // width pad with zeros.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] frame,
                                    input logic [POS_W-1:0]    pos);
    logic [SAMPLE_W-1:0] sh;
    sh = frame << (pos - 1'b1);
    if (pos == '0 || pos > LAST_POS) return 1'b0;
    return sh[SAMPLE_W-1];
  endfunction

  logic [0:0]           r_state;
  logic [SAMPLE_W-1:0]  r_hold;
  logic [SAMPLE_W-1:0]  r_frame;
  logic                 r_fresh;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_lrclk;
  logic                 r_sdata;
  logic                 r_sample_req;
  logic                 r_underrun;

  logic                 w_div_en;
  logic                 w_bclk;
  logic                 w_bclk_rise_unused;
  logic                 w_bclk_fall;
  logic                 w_wrap;
  logic                 w_stale;
  logic [BIT_CNT_W-1:0] w_bit_nx;
  logic [SAMPLE_W-1:0]  w_frame_nx;

  // The divider only runs in RUN while run stays high, so it restarts from
  // zero on every entry and bclk first rises BCLK_DIV clk after entry.
  assign w_div_en = (r_state == S_RUN) && bus.run;

  i2s_bclk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_div (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (w_div_en),
    .o_bclk    (w_bclk),
    // bits are launched on falling edges only
    .o_rise_en (w_bclk_rise_unused),
    .o_fall_en (w_bclk_fall)
  );

  assign w_wrap     = w_bclk_fall && (r_bit_cnt == LAST_BIT);
  assign w_bit_nx   = r_bit_cnt + 1'b1;
  // A strobe on the latch cycle bypasses the holding register.
  assign w_frame_nx = bus.data_valid ? bus.data_in : r_hold;
  assign w_stale    = !r_fresh && !bus.data_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_frame      <= '0;
      r_fresh      <= 1'b0;
      r_bit_cnt    <= '0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_sample_req <= 1'b0;

      if (bus.data_valid) begin
        r_hold  <= bus.data_in;
        r_fresh <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          r_lrclk   <= 1'b0;
          r_sdata   <= 1'b0;
          // Entry latch: never flags underrun; sdata starts at position 0.
          if (bus.run) begin
            r_state      <= S_RUN;
            r_frame      <= w_frame_nx;
            r_sample_req <= 1'b1;
            r_fresh      <= 1'b0;
          end
        end
        default: begin
          if (!bus.run) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_fresh   <= 1'b0;
            r_bit_cnt <= '0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
          end else if (w_bclk_fall) begin
            r_bit_cnt <= w_bit_nx;
            r_lrclk   <= w_bit_nx[BIT_CNT_W-1];
            // At the wrap the new position is 0, so the old frame is safe
            // to use here even though the frame register reloads.
            r_sdata   <= slot_bit(r_frame, w_bit_nx[POS_W-1:0]);
            if (w_wrap) begin
              r_frame      <= w_frame_nx;
              r_sample_req <= 1'b1;
              r_fresh      <= 1'b0;
              if (w_stale) r_underrun <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.bclk       = w_bclk;
  assign bus.lrclk      = r_lrclk;
  assign bus.sdata      = r_sdata;
  assign bus.sample_req = r_sample_req;
  assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_sine_tx.sv
// Directed bench for i2s_sine_tx with BCLK_DIV=2 (bclk period 4 clk,
// frame 256 clk). A sample table with hand-computed slot words drives the
// main loop; hand-written sequences cover underrun, coincidence, timing
// and abort.
module tb_i2s_sine_tx;

  localparam int BCLK_DIV = 2;
  localparam int SW       = 24;

  logic clk = 1'b0;
  logic reset;

  i2s_sine_tx_if #(.SAMPLE_W(SW)) bus ();

  i2s_sine_tx #(
    .BCLK_DIV (BCLK_DIV),
    .SAMPLE_W (SW)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sample;
    logic [31:0] slot;   // slot bits, position 0 in bit 31
  } vec_t;

  vec_t vecs [4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_dv(input logic [23:0] s);
    bus.data_valid = 1'b1;
    bus.data_in    = s;
    step();
    bus.data_valid = 1'b0;
  endtask

  // Steps until sample_req is seen; returns underrun of the cycle before.
  task automatic wait_req(input string name, output logic ur_before);
    logic ur_prev;
    bit   got;
    got     = 1'b0;
    ur_prev = bus.underrun;
    for (int i = 0; i < 300 && !got; i++) begin
      ur_prev = bus.underrun;
      step();
      got = bus.sample_req;
    end
    ur_before = ur_prev;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no sample_req within 300 clk", name);
    end
  endtask

  // Captures sdata/lrclk at the next 64 bclk rising edges and checks both
  // slots. Optionally pulses data_valid once mid-frame.
  task automatic check_frame(input string tag, input logic [31:0] exp,
                             input bit mid_en, input logic [23:0] mid_s);
    logic [63:0] d;
    logic [63:0] lr;
    logic        prev;
    bit          ok;
    bit          abort;
    d     = '0;
    lr    = '0;
    prev  = bus.bclk;
    abort = 1'b0;
    for (int b = 0; b < 64 && !abort; b++) begin
      ok = 1'b0;
      for (int t = 0; t < 4 * BCLK_DIV + 2 && !ok; t++) begin
        step();
        bus.data_valid = 1'b0;
        ok   = bus.bclk && !prev;
        prev = bus.bclk;
      end
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: bclk edge %0d missing", tag, b);
        abort = 1'b1;
      end else begin
        d[63-b]  = bus.sdata;
        lr[63-b] = bus.lrclk;
        if (b == 10 && mid_en) begin
          bus.data_valid = 1'b1;
          bus.data_in    = mid_s;
        end
      end
    end
    check32({tag, " left"},  d[63:32],  exp);
    check32({tag, " right"}, d[31:0],   exp);
    check32({tag, " lrclk left"},  lr[63:32], 32'h0000_0000);
    check32({tag, " lrclk right"}, lr[31:0],  32'hFFFF_FFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ur_b;
    int   rise1, rise2, lr1, nreq;
    logic pb;

    vecs[0] = '{24'h000000, 32'h0000_0000};
    vecs[1] = '{24'h800001, 32'h4000_0080};
    vecs[2] = '{24'hFFFFFF, 32'h7FFF_FF80};
    vecs[3] = '{24'hA5A5A5, 32'h52D2_D280};

    // ---- reset with run high ----
    reset          = 1'b1;
    bus.run        = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check1("bclk in reset", bus.bclk, 1'b0);
    end
    check32("outputs after reset",
            {27'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req, bus.underrun}, 32'd0);
    reset   = 1'b0;
    bus.run = 1'b0;
    step();
    check32("outputs in idle",
            {27'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req, bus.underrun}, 32'd0);

    // ---- table: sample fed one frame ahead, last frame runs stale ----
    pulse_dv(vecs[0].sample);
    bus.run = 1'b1;
    step();
    check1("entry sample_req", bus.sample_req, 1'b1);
    check1("entry underrun", bus.underrun, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) pulse_dv(vecs[k+1].sample);
      check_frame($sformatf("vec%0d", k), vecs[k].slot, 1'b0, 24'h0);
      wait_req($sformatf("vec%0d next latch", k), ur_b);
      check1($sformatf("vec%0d underrun at latch", k), bus.underrun, (k == 3));
    end
    check1("underrun before stale latch", ur_b, 1'b0);

    // stale frame repeats the last sample; two fresh samples, last wins
    pulse_dv(24'h123456);
    check_frame("stale repeat", 32'h52D2_D280, 1'b1, 24'h800001);
    wait_req("after stale", ur_b);
    check1("underrun sticky", bus.underrun, 1'b1);
    check_frame("last wins", 32'h4000_0080, 1'b0, 24'h0);

    // ---- reset, then timing and latch-cycle coincidence ----
    reset   = 1'b1;
    bus.run = 1'b0;
    step();
    step();
    check1("underrun cleared by reset", bus.underrun, 1'b0);
    reset   = 1'b0;
    bus.run = 1'b1;
    step();
    check1("entry2 sample_req", bus.sample_req, 1'b1);
    rise1 = -1;
    rise2 = -1;
    lr1   = -1;
    nreq  = 0;
    pb    = bus.bclk;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (bus.bclk && !pb) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      pb = bus.bclk;
      if (bus.lrclk && lr1 < 0) lr1 = i;
      if (bus.sample_req) nreq++;
    end
    check32("first bclk rise", rise1, 32'd2);
    check32("second bclk rise", rise2, 32'd6);
    check32("first lrclk rise", lr1, 32'd128);
    check32("sample_req inside frame", nreq, 32'd0);
    check1("underrun on entry latch", bus.underrun, 1'b0);

    bus.data_valid = 1'b1;
    bus.data_in    = 24'h123456;
    step();
    bus.data_valid = 1'b0;
    check1("sample_req at 256", bus.sample_req, 1'b1);
    check1("lrclk back to left", bus.lrclk, 1'b0);
    check1("coincide no underrun", bus.underrun, 1'b0);
    pulse_dv(24'hFFFFFF);
    check_frame("coincide", 32'h091A_2B00, 1'b0, 24'h0);
    wait_req("abort frame latch", ur_b);
    check1("abort frame underrun", bus.underrun, 1'b0);

    // ---- abort at bit_cnt 40 ----
    for (int i = 0; i < 162; i++) step();
    check32("before abort bclk/lrclk/sdata", {29'd0, bus.bclk, bus.lrclk, bus.sdata}, 32'd7);
    bus.run = 1'b0;
    step();
    check32("after abort", {28'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req}, 32'd0);
    step();
    step();
    check32("idle after abort", {28'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req}, 32'd0);
    pulse_dv(24'h800001);
    bus.run = 1'b1;
    step();
    check1("restart sample_req", bus.sample_req, 1'b1);
    check_frame("restart", 32'h4000_0080, 1'b0, 24'h0);
    check1("restart underrun", bus.underrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_sine_tx.md
Name: i2s_sine_tx

Overview:
- Downstream consumer of the sine generator's sample stream (data_valid pulse plus 24-bit sample).
- Serializes each sample onto a Philips-I2S output (bclk, lrclk, sdata) for the DAC, with the mono sample sent on both channels.
- Pulses sample_req once per frame.
- Raises a sticky underrun flag when a frame starts with no fresh sample.

Parameters:
- BCLK_DIV, 8, clk cycles per bclk half-period (>=1); bclk period = 2*BCLK_DIV clk.
- SAMPLE_W, 24, sample width (<=31).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  enable; low forces IDLE
- data_valid  in  1  one-cycle strobe, data_in valid
- data_in  in  SAMPLE_W  two's-complement sample
- bclk  out  1  I2S bit clock
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- sample_req  out  1  one-cycle pulse at each frame latch
- underrun  out  1  sticky; set when a frame re-sends a stale sample

Behaviour:
- All outputs are registers. Reset value of every output is 0; holding, frame and counter registers also clear to 0; state goes to IDLE.
- States:
  - IDLE: all outputs 0 except underrun, which holds its value.
  - RUN entered on the cycle after run=1 is seen in IDLE.
  - run=0 in RUN: next cycle returns to IDLE, clears bclk/lrclk/sdata/counters and the holding register. Mid-frame abort is allowed; no frame completion.
- Holding register: loads data_in on every data_valid; sets a fresh flag.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1; at terminal count bclk toggles and div_cnt wraps.
  - In RUN, bclk rises first BCLK_DIV clk after entry.
  - bit_cnt (0..63) increments on each bclk falling toggle, wrapping 63->0.
- Frame latch: occurs on RUN entry and on every 63->0 wrap.
  - Frame register <= holding; sample_req=1 for that one cycle.
  - data_valid coincident with the latch cycle bypasses: frame gets data_in, and the sample counts as fresh.
  - If no fresh sample: frame repeats the previous value and underrun <= 1.
  - fresh flag is cleared at every latch.
- Outputs during RUN:
  - lrclk = bit_cnt[5]; changes together with bclk falling.
  - Slot position p = bit_cnt[4:0]:
    - p=0 → sdata 0 (I2S one-bit delay).
    - p=1..SAMPLE_W → sample bit SAMPLE_W-p.
    - p > SAMPLE_W → 0.
  - Both slots carry the same frame register.
  - sdata updates only on bclk falling edges (and at RUN entry); it is stable across the rising edge.
- underrun: cleared only by reset. It is not set on the RUN-entry latch.
- Latency: data_valid → MSB on sdata at slot position 1 of the next frame.
- Throughput: one sample per 128*BCLK_DIV clk. Extra data_valid within a frame overwrite holding; the last one wins, with no error.

Decomposition:
- Shared package i2s_pkg holds:
  - SLOT_BITS=32, FRAME_BITS=64
  - state enum {IDLE, RUN}
  - default SAMPLE_W=24
- One natural sub-module: i2s_bclk_div, containing div_cnt and the bclk toggle, producing bclk, rise_en and fall_en strobes; parameter BCLK_DIV.
- Shift/slot logic stays in the top module.

Test Plan:
- Reset: assert reset 3 cycles with run=1 → bclk, lrclk, sdata, sample_req, underrun all 0, and bclk stays 0 during reset.
- Timing, BCLK_DIV=2, run held high:
  - bclk period 4 clk.
  - lrclk toggles every 128 clk.
  - sample_req pulses every 256 clk and on the cycle after RUN entry.
- Serial pattern, data_in=0x800001 before the latch → each slot reads 0,1,22×0,1,7×0 at bclk rising edges; the left slot equals the right slot.
- Underrun: supply one sample, then none → second frame repeats the sample, underrun=1 from that latch cycle, and underrun stays 1 after later fresh samples.
- Coincidence: data_valid with 0x123456 on the exact latch cycle → that frame transmits 0x123456 and underrun stays 0.
- Abort: drop run at bit_cnt=40 → next cycle bclk=lrclk=sdata=0. Re-assert run → new frame from bit 0 with a sample_req pulse.
